preload_sequencer: RTL and testbench
====================================

Name: preload_sequencer

Overview:
- Host-side controller that streams preprocessed clause and pointer-table data from two read-only memories into the engine latency buffer.
- Sequence per engine: all of the engine's clauses, then exactly one full pointer table of 2*LIT_IDX_MAX+1 entries, then one engine-advance pulse before the next engine.
- Sits between the preprocess memories and the latency buffer's load_clause_in / load_ptr_in / load_change_engine_in inputs.
- Provides start/busy/done to the top-level solver control.

Parameters:
NUM_ENGINE, 4, number of BCP engines to load
LIT_IDX_MAX, 8, max literal index; pointer table size PTR_ENTRIES = 2*LIT_IDX_MAX+1
CLAUSE_ADDR_W, 10, clause memory address width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a load sequence when idle
clause_cnt_in  in  NUM_ENGINE*(CLAUSE_ADDR_W+1)  per-engine clause count, slice e = engine e; sampled on accepted start
clause_rd_req  out  1  clause memory read request, one-cycle pulse
clause_rd_addr  out  CLAUSE_ADDR_W  clause read address
clause_rd_valid  in  1  clause read data valid
clause_rd_data  in  node_t  clause read data
ptr_rd_req  out  1  pointer memory read request, one-cycle pulse
ptr_rd_addr  out  $clog2(NUM_ENGINE*PTR_ENTRIES)  pointer read address
ptr_rd_valid  in  1  pointer read data valid
ptr_rd_data  in  dummy_entry_t  pointer read data
clause_out  out  node_t  clause to latency buffer
load_clause_out  out  1  clause_out valid
ptr_out  out  dummy_entry_t  pointer entry to latency buffer
load_ptr_out  out  1  ptr_out valid
load_change_engine_out  out  1  engine-advance pulse
engine_idx  out  $clog2(NUM_ENGINE)  engine currently being loaded
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset: all outputs 0; state IDLE; counters, addresses and outstanding flags cleared. Reset mid-sequence aborts immediately. Responses arriving after reset are ignored (outstanding flag cleared).
- States: IDLE, CLS, PTR, CHG, FIN.
- IDLE:
  - start=1: latch clause_cnt_in, engine_idx=0, clause_addr=0, ptr_addr=0, busy=1 next cycle.
  - Next state is CLS, or PTR if engine 0's count is 0.
  - start while busy is ignored.
- CLS: issue clause reads with at most one outstanding.
  - Next request may issue in the same cycle rd_valid is seen.
  - Each rd_valid registers clause_out=rd_data with load_clause_out=1 in the following cycle.
  - clause_addr increments per request and wraps mod 2^CLAUSE_ADDR_W.
  - After the count-th response is received, go to PTR.
- PTR: same handshake on the pointer port for exactly PTR_ENTRIES reads.
  - ptr_rd_addr = engine_idx*PTR_ENTRIES + j.
  - Each response gives a one-cycle load_ptr_out with ptr_out.
  - After the last response: go to CHG if engine_idx < NUM_ENGINE-1, else FIN.
- CHG (one cycle): load_change_engine_out=1 and engine_idx++.
  - This pulse is registered, so it precedes the new engine's first load_clause_out by at least 2 cycles.
  - Next state is CLS, or PTR if the new engine's count is 0.
- FIN (one cycle): done=1, busy=0 next cycle, return to IDLE.
- Ordering guarantees, always held:
  - Never load_clause_out and load_ptr_out in the same cycle.
  - Never a change pulse in the same cycle as any load.
  - Exactly NUM_ENGINE*PTR_ENTRIES pointer loads and NUM_ENGINE-1 change pulses per sequence.
- rd_valid without an outstanding request is ignored.
- No downstream backpressure; the sequencer never stalls an accepted response.

Decomposition:
- node_t, dummy_entry_t, NUM_ENGINE, LIT_IDX_MAX belong in the shared solver package; add PTR_ENTRIES there as a derived constant.
- Sub-module preload_rd_port: single-outstanding read tracker (req pulse, outstanding flag, element counter, data register, completion flag). Instantiated twice, clause and pointer, parameterised by data type and address width.

Test Plan:
- NUM_ENGINE=4, LIT_IDX_MAX=2, counts {3,1,2,2}, 1-cycle memory latency, start -> 8 clause loads at addresses 0..7 in order, 20 ptr loads at addresses 0..19, 3 change pulses each between engine groups, done after last ptr load, busy deasserts.
- Counts {0,2,0,0} -> engine 0 skips CLS (first output is a ptr load), total clause loads 2, ptr loads 20, change pulses 3.
- Memory latency 3 cycles, randomized per read -> never two requests outstanding on a port; output order and data match the memory image exactly.
- Reset asserted during engine 1 PTR at entry 2, with a response arriving 1 cycle after reset -> all outputs 0, the late response is not forwarded; a fresh start replays from address 0 with engine_idx=0.
- start pulsed while busy and again in the FIN cycle -> both ignored; one start after return to IDLE yields exactly one new sequence.
- Spurious clause_rd_valid=1 in IDLE and CHG -> no load_clause_out, counters unchanged.

Source files
------------

// File: rtl/preload_sequencer_pkg.sv
// Shared solver types and sizing for the preload path.
// PTR_ENTRIES is derived: one slot per signed literal plus the null literal.
package preload_sequencer_pkg;

    localparam int NUM_ENGINE    = 4;
    localparam int LIT_IDX_MAX   = 8;
    localparam int PTR_ENTRIES   = 2*LIT_IDX_MAX+1;
    localparam int CLAUSE_ADDR_W = 10;

    typedef struct packed {
        logic [7:0] lit_a;
        logic [7:0] lit_b;
        logic [7:0] lit_c;
    } node_t;

    typedef struct packed {
        logic       vld;
        logic [9:0] head;
    } dummy_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        CLS,
        PTR,
        CHG,
        FIN
    } seq_state_t;

endpackage

// File: rtl/preload_sequencer_rd_port.sv
// Single-outstanding read tracker: issues count reads, registers each response for one cycle.
// The address keeps running across bursts so consecutive engines read contiguous regions.
module preload_rd_port
    import preload_sequencer_pkg::*;
#(
    parameter type T      = logic,
    parameter int  ADDR_W = 4,
    parameter int  CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  T                  rd_data,
    output T                  data_out,
    output logic              data_vld,
    output logic              complete
);

    logic              run_q, run_d;
    logic              outs_q, outs_d;
    logic              vld_q, vld_d;
    logic              cmp_q, cmp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  iss_q, iss_d;
    logic [CNT_W-1:0]  rsp_q, rsp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    T                  data_q, data_d;
    logic              accept, issue, last;

    always_comb begin
        accept = outs_q & rd_valid;
        // A response frees the slot in the same cycle, so the next request may go out alongside it.
        issue  = run_q & (iss_q != cnt_q) & (~outs_q | rd_valid);
        last   = accept & ((rsp_q + CNT_W'(1)) == cnt_q);

        run_d  = run_q;
        outs_d = outs_q;
        cnt_d  = cnt_q;
        iss_d  = iss_q;
        rsp_d  = rsp_q;
        addr_d = addr_q;
        data_d = data_q;
        vld_d  = accept;
        cmp_d  = last;

        if (accept) begin
            outs_d = 1'b0;
            rsp_d  = rsp_q + CNT_W'(1);
            data_d = rd_data;
        end
        if (issue) begin
            outs_d = 1'b1;
            iss_d  = iss_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
        end
        if (last) begin
            run_d = 1'b0;
        end
        if (start) begin
            run_d = 1'b1;
            cnt_d = count;
            iss_d = '0;
            rsp_d = '0;
        end
        if (clear) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q  <= 1'b0;
            outs_q <= 1'b0;
            vld_q  <= 1'b0;
            cmp_q  <= 1'b0;
            cnt_q  <= '0;
            iss_q  <= '0;
            rsp_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            run_q  <= run_d;
            outs_q <= outs_d;
            vld_q  <= vld_d;
            cmp_q  <= cmp_d;
            cnt_q  <= cnt_d;
            iss_q  <= iss_d;
            rsp_q  <= rsp_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign rd_req   = issue;
    assign rd_addr  = addr_q;
    assign data_out = data_q;
    assign data_vld = vld_q;
    assign complete = cmp_q;

endmodule

// File: rtl/preload_sequencer.sv
// Streams each engine's clauses, then its pointer table, then an engine-advance pulse, into the latency buffer.
// Loads appear one cycle after each memory response; no downstream backpressure.
module preload_sequencer #(
    parameter int  NUM_ENGINE    = preload_sequencer_pkg::NUM_ENGINE,
    parameter int  LIT_IDX_MAX   = preload_sequencer_pkg::LIT_IDX_MAX,
    parameter int  CLAUSE_ADDR_W = preload_sequencer_pkg::CLAUSE_ADDR_W,
    localparam int PTR_ENTRIES   = 2*LIT_IDX_MAX+1,
    localparam int PTR_ADDR_W    = $clog2(NUM_ENGINE*PTR_ENTRIES),
    localparam int ENG_W         = $clog2(NUM_ENGINE),
    localparam int CNT_W         = CLAUSE_ADDR_W+1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NUM_ENGINE*CNT_W-1:0]         clause_cnt_in,
    output logic                                clause_rd_req,
    output logic [CLAUSE_ADDR_W-1:0]            clause_rd_addr,
    input  logic                                clause_rd_valid,
    input  preload_sequencer_pkg::node_t        clause_rd_data,
    output logic                                ptr_rd_req,
    output logic [PTR_ADDR_W-1:0]               ptr_rd_addr,
    input  logic                                ptr_rd_valid,
    input  preload_sequencer_pkg::dummy_entry_t ptr_rd_data,
    output preload_sequencer_pkg::node_t        clause_out,
    output logic                                load_clause_out,
    output preload_sequencer_pkg::dummy_entry_t ptr_out,
    output logic                                load_ptr_out,
    output logic                                load_change_engine_out,
    output logic [ENG_W-1:0]                    engine_idx,
    output logic                                busy,
    output logic                                done
);
    import preload_sequencer_pkg::*;

    localparam int PTR_CNT_W = $clog2(PTR_ENTRIES+1);

    seq_state_t                  state_q, state_d;
    logic [ENG_W-1:0]            eng_q, eng_d;
    logic [NUM_ENGINE*CNT_W-1:0] cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        chg_q, chg_d;
    logic                        cls_start, ptr_start, seq_clear;
    logic                        cls_cmp, ptr_cmp;
    logic [CNT_W-1:0]            cls_cnt, cur_cnt, first_cnt;

    always_comb begin
        cur_cnt   = cnt_q[eng_q*CNT_W +: CNT_W];
        first_cnt = clause_cnt_in[CNT_W-1:0];

        state_d   = state_q;
        eng_d     = eng_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        chg_d     = 1'b0;
        cls_start = 1'b0;
        ptr_start = 1'b0;
        seq_clear = 1'b0;
        cls_cnt   = cur_cnt;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = clause_cnt_in;
                    eng_d     = '0;
                    busy_d    = 1'b1;
                    seq_clear = 1'b1;
                    cls_cnt   = first_cnt;
                    if (first_cnt == '0) begin
                        state_d   = PTR;
                        ptr_start = 1'b1;
                    end else begin
                        state_d   = CLS;
                        cls_start = 1'b1;
                    end
                end
            end
            CLS: begin
                if (cls_cmp) begin
                    state_d   = PTR;
                    ptr_start = 1'b1;
                end
            end
            PTR: begin
                if (ptr_cmp) begin
                    if (eng_q == ENG_W'(NUM_ENGINE-1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CHG;
                        chg_d   = 1'b1;
                        eng_d   = eng_q + ENG_W'(1);
                    end
                end
            end
            CHG: begin
                // eng_q already points at the new engine here.
                if (cur_cnt == '0) begin
                    state_d   = PTR;
                    ptr_start = 1'b1;
                end else begin
                    state_d   = CLS;
                    cls_start = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            eng_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            eng_q   <= eng_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            chg_q   <= chg_d;
        end
    end

    preload_rd_port #(
        .T      (node_t),
        .ADDR_W (CLAUSE_ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cls_port (
        .clock    (clock),
        .reset    (reset),
        .clear    (seq_clear),
        .start    (cls_start),
        .count    (cls_cnt),
        .rd_req   (clause_rd_req),
        .rd_addr  (clause_rd_addr),
        .rd_valid (clause_rd_valid),
        .rd_data  (clause_rd_data),
        .data_out (clause_out),
        .data_vld (load_clause_out),
        .complete (cls_cmp)
    );

    preload_rd_port #(
        .T      (dummy_entry_t),
        .ADDR_W (PTR_ADDR_W),
        .CNT_W  (PTR_CNT_W)
    ) u_ptr_port (
        .clock    (clock),
        .reset    (reset),
        .clear    (seq_clear),
        .start    (ptr_start),
        .count    (PTR_CNT_W'(PTR_ENTRIES)),
        .rd_req   (ptr_rd_req),
        .rd_addr  (ptr_rd_addr),
        .rd_valid (ptr_rd_valid),
        .rd_data  (ptr_rd_data),
        .data_out (ptr_out),
        .data_vld (load_ptr_out),
        .complete (ptr_cmp)
    );

    assign load_change_engine_out = chg_q;
    assign engine_idx             = eng_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule

// File: tb/tb_preload_sequencer.sv
// Randomised bench: memory models with variable latency feed the sequencer; a scoreboard
// built from the load-order rules checks every emitted load, change pulse and done.
module tb_preload_sequencer;
    import preload_sequencer_pkg::*;

    localparam int NE = 4;
    localparam int PE = 5;
    localparam int CW = 11;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NE*CW-1:0] clause_cnt_in = '0;
    logic            clause_rd_req;
    logic [9:0]      clause_rd_addr;
    logic            clause_rd_valid = 1'b0;
    node_t           clause_rd_data = '0;
    logic            ptr_rd_req;
    logic [4:0]      ptr_rd_addr;
    logic            ptr_rd_valid = 1'b0;
    dummy_entry_t    ptr_rd_data = '0;
    node_t           clause_out;
    logic            load_clause_out;
    dummy_entry_t    ptr_out;
    logic            load_ptr_out;
    logic            load_change_engine_out;
    logic [1:0]      engine_idx;
    logic            busy;
    logic            done;

    preload_sequencer #(.NUM_ENGINE(NE), .LIT_IDX_MAX(2), .CLAUSE_ADDR_W(10)) dut (
        .clock(clock), .reset(reset), .start(start), .clause_cnt_in(clause_cnt_in),
        .clause_rd_req(clause_rd_req), .clause_rd_addr(clause_rd_addr),
        .clause_rd_valid(clause_rd_valid), .clause_rd_data(clause_rd_data),
        .ptr_rd_req(ptr_rd_req), .ptr_rd_addr(ptr_rd_addr),
        .ptr_rd_valid(ptr_rd_valid), .ptr_rd_data(ptr_rd_data),
        .clause_out(clause_out), .load_clause_out(load_clause_out),
        .ptr_out(ptr_out), .load_ptr_out(load_ptr_out),
        .load_change_engine_out(load_change_engine_out),
        .engine_idx(engine_idx), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 clause, 1 ptr, 2 change, 3 done
        logic [31:0] dat;
        int          eng;
    } ev_t;

    ev_t         exp_q[$];
    logic [23:0] clause_mem [1024];
    logic [10:0] ptr_mem [NE*PE];
    int total = 0, bad = 0;
    int cl_lat_mode = 0, pt_lat_mode = 0;
    bit spur_en = 0, mon_en = 0;
    int n_cls = 0, n_ptr = 0, n_chg = 0;
    bit done_seen = 0, busy_chk = 0, chg_pending = 0;
    int cyc = 0, last_chg = 0;

    task automatic chk(string nm, int act, int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, req);
        end
    endtask

    task automatic expect_ev(int kind, logic [31:0] dat);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d dat=%0h with nothing expected", kind, dat);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.dat !== dat || e.eng != int'(engine_idx)) begin
                bad++;
                $display("FAIL event_order got kind=%0d dat=%0h eng=%0d want kind=%0d dat=%0h eng=%0d",
                         kind, dat, engine_idx, e.kind, e.dat, e.eng);
            end
        end
    endtask

    function automatic int lat(int mode);
        if (mode == 0) return 1;
        if (mode == 1) return $urandom_range(1, 3);
        return 2;
    endfunction

    // Reference order: per engine its clauses from a running address, its pointer table,
    // then a change pulse (engine index already advanced), and done at the very end.
    task automatic push_model(input int c [NE]);
        int a = 0;
        for (int e = 0; e < NE; e++) begin
            for (int k = 0; k < c[e]; k++) begin
                exp_q.push_back('{0, {8'h0, clause_mem[a % 1024]}, e});
                a++;
            end
            for (int j = 0; j < PE; j++)
                exp_q.push_back('{1, {21'h0, ptr_mem[e*PE + j]}, e});
            if (e < NE-1) exp_q.push_back('{2, 32'h0, e+1});
        end
        exp_q.push_back('{3, 32'h0, NE-1});
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load_counts(input int c [NE]);
        for (int e = 0; e < NE; e++) clause_cnt_in[e*CW +: CW] = CW'(c[e]);
        push_model(c);
        n_cls = 0; n_ptr = 0; n_chg = 0; done_seen = 0;
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (!done_seen && k < budget) begin tick(1); k++; end
        chk("done_within_budget", int'(done_seen), 1);
    endtask

    task automatic run_seq(input int c [NE]);
        int sum = 0;
        for (int e = 0; e < NE; e++) sum += c[e];
        load_counts(c);
        pulse_start();
        wait_done(3000);
        tick(2);
        chk("queue_drained", exp_q.size(), 0);
        chk("clause_loads", n_cls, sum);
        chk("ptr_loads", n_ptr, NE*PE);
        chk("change_pulses", n_chg, NE-1);
    endtask

    // Clause memory model
    bit cl_pend = 0; int cl_rem = 0; logic [9:0] cl_a = '0;
    initial forever begin
        logic [31:0] r;
        @(posedge clock); #1;
        clause_rd_valid = 1'b0;
        clause_rd_data  = '0;
        if (cl_pend) begin
            if (cl_rem <= 1) begin
                clause_rd_valid = 1'b1;
                clause_rd_data  = clause_mem[cl_a];
                cl_pend = 0;
            end else cl_rem--;
        end else if (spur_en && (!busy || load_change_engine_out)) begin
            r = $urandom;
            clause_rd_valid = 1'b1;
            clause_rd_data  = r[23:0];
        end
        @(negedge clock);
        if (clause_rd_req) begin
            chk("clause_single_outstanding", int'(cl_pend), 0);
            cl_pend = 1; cl_rem = lat(cl_lat_mode); cl_a = clause_rd_addr;
        end
    end

    // Pointer memory model
    bit pt_pend = 0; int pt_rem = 0; logic [4:0] pt_a = '0;
    initial forever begin
        @(posedge clock); #1;
        ptr_rd_valid = 1'b0;
        ptr_rd_data  = '0;
        if (pt_pend) begin
            if (pt_rem <= 1) begin
                ptr_rd_valid = 1'b1;
                ptr_rd_data  = ptr_mem[pt_a];
                pt_pend = 0;
            end else pt_rem--;
        end
        @(negedge clock);
        if (ptr_rd_req) begin
            chk("ptr_single_outstanding", int'(pt_pend), 0);
            pt_pend = 1; pt_rem = lat(pt_lat_mode); pt_a = ptr_rd_addr;
        end
    end

    // Monitor / scoreboard
    always @(negedge clock) begin
        int nev;
        cyc = cyc + 1;
        if (mon_en) begin
            nev = int'(load_clause_out) + int'(load_ptr_out) + int'(load_change_engine_out);
            if (nev != 0) chk("one_event_per_cycle", nev, 1);
            if (busy_chk) begin chk("busy_after_done", int'(busy), 0); busy_chk = 0; end
            if (load_clause_out) begin
                expect_ev(0, {8'h0, clause_out});
                n_cls++;
                if (chg_pending) begin
                    chk("change_to_clause_gap", int'((cyc - last_chg) >= 2), 1);
                    chg_pending = 0;
                end
            end
            if (load_ptr_out) begin
                expect_ev(1, {21'h0, ptr_out});
                n_ptr++;
                chg_pending = 0;
            end
            if (load_change_engine_out) begin
                expect_ev(2, 32'h0);
                n_chg++;
                last_chg = cyc;
                chg_pending = 1;
            end
            if (done) begin
                expect_ev(3, 32'h0);
                chk("busy_in_fin", int'(busy), 1);
                done_seen = 1;
                busy_chk  = 1;
            end
        end
    end

    initial begin
        int c [NE];
        int k;
        bit found;
        for (int i = 0; i < 1024; i++) clause_mem[i] = 24'($urandom);
        for (int i = 0; i < NE*PE; i++) ptr_mem[i] = 11'($urandom);

        tick(3);
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_loads", int'({load_clause_out, load_ptr_out, load_change_engine_out}), 0);
        chk("rst_reqs", int'({clause_rd_req, ptr_rd_req}), 0);
        chk("rst_engine_idx", int'(engine_idx), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        mon_en = 1;
        tick(2);

        c = '{3, 1, 2, 2};
        run_seq(c);
        c = '{0, 2, 0, 0};
        run_seq(c);

        cl_lat_mode = 1; pt_lat_mode = 1;
        for (int it = 0; it < 3; it++) begin
            for (int e = 0; e < NE; e++) c[e] = $urandom_range(0, 4);
            run_seq(c);
        end

        // Abort during engine 1 pointer entry 2 with the response landing just after reset.
        cl_lat_mode = 0; pt_lat_mode = 2;
        c = '{1, 1, 1, 1};
        load_counts(c);
        pulse_start();
        k = 0; found = 0;
        while (!found && k < 500) begin
            @(negedge clock);
            if (ptr_rd_req && ptr_rd_addr == 5'd7) found = 1;
            k++;
        end
        chk("reached_eng1_ptr2", int'(found), 1);
        mon_en = 0;
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_loads", int'({load_clause_out, load_ptr_out, load_change_engine_out, done}), 0);
        chk("abort_reqs", int'({clause_rd_req, ptr_rd_req}), 0);
        chk("abort_engine_idx", int'(engine_idx), 0);
        @(negedge clock);
        chk("late_rsp_dropped", int'(load_ptr_out), 0);
        tick(3);
        mon_en = 1;
        pt_lat_mode = 1;
        c = '{2, 0, 3, 1};
        run_seq(c);

        // start while busy and during the FIN cycle must both be ignored.
        cl_lat_mode = 0; pt_lat_mode = 0;
        c = '{1, 2, 1, 0};
        load_counts(c);
        pulse_start();
        tick(4);
        pulse_start();
        k = 0; found = 0;
        while (!found && k < 2000) begin
            @(negedge clock);
            if (done) found = 1;
            k++;
        end
        chk("fin_reached", int'(found), 1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        tick(6);
        chk("idle_after_ignored_starts", int'(busy), 0);
        chk("no_extra_sequence", exp_q.size(), 0);
        c = '{1, 1, 2, 0};
        run_seq(c);

        // Spurious clause responses in IDLE and CHG must not create loads.
        spur_en = 1;
        tick(5);
        c = '{2, 1, 0, 3};
        run_seq(c);
        spur_en = 0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
